// File: rtl/fetch_unit.sv
// Instruction fetch unit: one-outstanding-request fetch FSM feeding a prefetch queue.
// Optional build macro ARVI_FETCH_MISALIGN_EN adds misaligned-redirect trap outputs.
module fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    output logic                    o_req,
    output logic [XLEN-1:0]         o_addr,
    input  logic                    i_ack,
    input  logic [31:0]             i_rdata,
    output logic                    o_valid,
    output logic [31:0]             o_instr,
    output logic [XLEN-1:0]         o_pc,
    input  logic                    i_ready,
    input  logic                    i_redirect,
    input  logic [XLEN-1:0]         i_redirect_pc,
    output logic [$clog2(DEPTH):0]  o_count
`ifdef ARVI_FETCH_MISALIGN_EN
    ,
    output logic                    o_ex_inst_addr,
    output logic [XLEN-1:0]         o_badaddr
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDrop
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0]   mem_pc_q    [DEPTH];
    logic [31:0]       mem_instr_q [DEPTH];

    logic              push, pop;
    logic [CNT_W-1:0]  count_after;
    logic [XLEN-1:0]   tgt_pc;
    logic              tgt_ok;
    logic              fetch_en;

`ifdef ARVI_FETCH_MISALIGN_EN
    logic              ex_q, ex_d;
    logic [XLEN-1:0]   bad_q, bad_d;

    assign tgt_pc   = i_redirect_pc;
    assign tgt_ok   = (i_redirect_pc[1:0] == 2'b00);
    assign fetch_en = !ex_q;

    always_comb begin
        ex_d  = ex_q;
        bad_d = bad_q;
        if (i_redirect) begin
            ex_d  = !tgt_ok;
            bad_d = tgt_ok ? '0 : i_redirect_pc;
        end
    end

    assign o_ex_inst_addr = ex_q;
    assign o_badaddr      = bad_q;
`else
    logic unused_redirect_lsb;

    // Targets are forced word-aligned instead of trapping.
    assign tgt_pc              = {i_redirect_pc[XLEN-1:2], 2'b00};
    assign tgt_ok              = 1'b1;
    assign fetch_en            = 1'b1;
    assign unused_redirect_lsb = ^i_redirect_pc[1:0];
`endif

    assign o_req   = (state_q != StIdle);
    assign o_addr  = addr_q;
    assign o_count = count_q;
    assign o_valid = (count_q != '0);
    assign o_instr = o_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign o_pc    = o_valid ? mem_pc_q[rd_ptr_q] : '0;

    assign push        = (state_q == StWait) && i_ack && !i_redirect;
    assign pop         = o_valid && i_ready && !i_redirect;
    assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);

    always_comb begin
        count_d  = count_after;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        if (i_redirect) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        if (i_redirect) begin
            pc_d = tgt_pc;
            if (state_q != StIdle && !i_ack) begin
                // Request still in flight: hold its address, discard its data later.
                state_d = StDrop;
            end else if (tgt_ok) begin
                // Queue is emptied this edge, so the target can be fetched immediately.
                state_d = StWait;
                addr_d  = tgt_pc;
            end else begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q < DEPTH_C && fetch_en) begin
                        state_d = StWait;
                        addr_d  = pc_q;
                    end
                end
                StWait: begin
                    if (i_ack) begin
                        pc_d = addr_q + XLEN'(4);
                        if (count_after < DEPTH_C) begin
                            addr_d = addr_q + XLEN'(4);
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                StDrop: begin
                    if (i_ack) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q  <= StIdle;
            addr_q   <= PC_RESET;
            pc_q     <= PC_RESET;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
`ifdef ARVI_FETCH_MISALIGN_EN
            ex_q     <= 1'b0;
            bad_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef ARVI_FETCH_MISALIGN_EN
            ex_q     <= ex_d;
            bad_q    <= bad_d;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst && push) begin
            mem_pc_q[wr_ptr_q]    <= addr_q;
            mem_instr_q[wr_ptr_q] <= i_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a queue-based model of the fetch/queue behaviour.
module tb_fetch_unit;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] PC_RESET = 32'h0;

    logic        i_clk;
    logic        i_rst;
    logic        o_req;
    logic [31:0] o_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        o_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        i_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic [2:0]  o_count;
`ifdef ARVI_FETCH_MISALIGN_EN
    logic        o_ex_inst_addr;
    logic [31:0] o_badaddr;
`endif

    fetch_unit #(
        .XLEN     (XLEN),
        .PC_RESET (PC_RESET),
        .DEPTH    (DEPTH)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .o_req          (o_req),
        .o_addr         (o_addr),
        .i_ack          (i_ack),
        .i_rdata        (i_rdata),
        .o_valid        (o_valid),
        .o_instr        (o_instr),
        .o_pc           (o_pc),
        .i_ready        (i_ready),
        .i_redirect     (i_redirect),
        .i_redirect_pc  (i_redirect_pc),
        .o_count        (o_count)
`ifdef ARVI_FETCH_MISALIGN_EN
        ,
        .o_ex_inst_addr (o_ex_inst_addr),
        .o_badaddr      (o_badaddr)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an outstanding request (busy/drop), the next fetch address and a plain queue.
    logic [63:0] mq[$];
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    logic [31:0] m_next;
    bit          live = 1'b0;
    bit          hold_off = 1'b0;
    int          n0;
    logic [31:0] tgt;

    always @(posedge i_clk) begin
        if (!i_rst) begin
            mq.delete();
            m_busy = 1'b0;
            m_drop = 1'b0;
            m_addr = PC_RESET;
            m_next = PC_RESET;
            live   = 1'b1;
        end else if (i_redirect) begin
            tgt = i_redirect_pc & ~32'h3;
            mq.delete();
            m_next = tgt;
            if (m_busy && !i_ack) begin
                m_drop = 1'b1;
            end else begin
                m_busy = 1'b1;
                m_drop = 1'b0;
                m_addr = tgt;
            end
        end else begin
            n0 = mq.size();
            if (n0 > 0 && i_ready) void'(mq.pop_front());
            if (m_busy && i_ack) begin
                if (m_drop) begin
                    m_busy = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    mq.push_back({m_addr, i_rdata});
                    m_next = m_addr + 32'd4;
                    if (mq.size() < DEPTH) m_addr = m_next;
                    else m_busy = 1'b0;
                end
            end else if (!m_busy && n0 < DEPTH) begin
                m_busy = 1'b1;
                m_addr = m_next;
            end
        end
    end

    logic [31:0] e_pc;
    logic [31:0] e_instr;

    always @(negedge i_clk) begin
        if (live && !hold_off) begin
            e_pc    = (mq.size() != 0) ? mq[0][63:32] : 32'h0;
            e_instr = (mq.size() != 0) ? mq[0][31:0] : 32'h0;
            check("m_req", 64'(o_req), 64'(m_busy));
            if (m_busy) check("m_addr", 64'(o_addr), 64'(m_addr));
            check("m_count", 64'(o_count), 64'(mq.size()));
            check("m_valid", 64'(o_valid), 64'(mq.size() != 0));
            check("m_pc", 64'(o_pc), 64'(e_pc));
            check("m_instr", 64'(o_instr), 64'(e_instr));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
        i_rdata = $urandom;
    endtask

    initial begin
        i_rst         = 1'b0;
        i_ack         = 1'b0;
        i_ready       = 1'b0;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_rdata       = $urandom;
        repeat (3) tick();
        check("rst_req", 64'(o_req), 64'd0);
        check("rst_addr", 64'(o_addr), 64'(PC_RESET));
        check("rst_count", 64'(o_count), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_instr", 64'(o_instr), 64'd0);
        check("rst_pc", 64'(o_pc), 64'd0);

        // Fill from reset with ack tied high.
        i_rst = 1'b1;
        i_ack = 1'b1;
        tick();
        check("fill_req", 64'(o_req), 64'd1);
        check("fill_addr0", 64'(o_addr), 64'h0);
        repeat (4) tick();
        check("fill_count", 64'(o_count), 64'd4);
        check("fill_reqdrop", 64'(o_req), 64'd0);
        check("fill_head", 64'(o_pc), 64'h0);
        repeat (2) tick();
        check("fill_hold", 64'(o_count), 64'd4);

        // One pop while full allows exactly one more fetch.
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("pop_count", 64'(o_count), 64'd3);
        check("pop_head", 64'(o_pc), 64'h4);
        tick();
        check("refetch_req", 64'(o_req), 64'd1);
        check("refetch_addr", 64'(o_addr), 64'h10);
        tick();
        check("refill_count", 64'(o_count), 64'd4);
        repeat (3) tick();
        check("refill_noreq", 64'(o_req), 64'd0);

        // Redirect while waiting without ack: old data is dropped.
        i_ack   = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        tick();
        check("wait_addr", 64'(o_addr), 64'h14);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h100;
        tick();
        i_redirect = 1'b0;
        check("drop_count", 64'(o_count), 64'd0);
        check("drop_req", 64'(o_req), 64'd1);
        check("drop_addr", 64'(o_addr), 64'h14);
        repeat (2) tick();
        i_ack = 1'b1;
        tick();
        i_ack = 1'b0;
        check("drop_done_req", 64'(o_req), 64'd0);
        check("drop_done_valid", 64'(o_valid), 64'd0);
        tick();
        check("redir_addr", 64'(o_addr), 64'h100);
        i_ack = 1'b1;
        tick();
        check("redir_valid", 64'(o_valid), 64'd1);
        check("redir_head", 64'(o_pc), 64'h100);

        // Redirect coinciding with ack and ready.
        i_ready       = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h200;
        tick();
        check("ackredir_count", 64'(o_count), 64'd0);
        check("ackredir_req", 64'(o_req), 64'd1);
        check("ackredir_addr", 64'(o_addr), 64'h200);

        // Fetch address wraps past the top of the address space.
        i_ready       = 1'b0;
        i_redirect_pc = 32'hFFFF_FFFC;
        tick();
        i_redirect = 1'b0;
        tick();
        check("wrap_addr", 64'(o_addr), 64'h0);
        check("wrap_head", 64'(o_pc), 64'hFFFF_FFFC);

`ifdef ARVI_FETCH_MISALIGN_EN
        hold_off      = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h102;
        tick();
        i_redirect = 1'b0;
        i_ack      = 1'b0;
        check("mis_flag", 64'(o_ex_inst_addr), 64'd1);
        check("mis_bad", 64'(o_badaddr), 64'h102);
        check("mis_req", 64'(o_req), 64'd0);
        repeat (2) tick();
        check("mis_suppress", 64'(o_req), 64'd0);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h80;
        tick();
        i_redirect = 1'b0;
        check("mis_clear", 64'(o_ex_inst_addr), 64'd0);
        check("mis_clear_bad", 64'(o_badaddr), 64'h0);
        check("mis_refetch", 64'(o_addr), 64'h80);
`else
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h102;
        tick();
        i_redirect = 1'b0;
        i_ack      = 1'b0;
        check("align_addr", 64'(o_addr), 64'h100);
`endif

        // Reset in the middle of an outstanding request.
        i_rst = 1'b0;
        tick();
        hold_off = 1'b0;
        check("midrst_req", 64'(o_req), 64'd0);
        i_rst = 1'b1;
        tick();
        check("postrst_req", 64'(o_req), 64'd1);
        check("postrst_addr", 64'(o_addr), 64'(PC_RESET));

        for (int i = 0; i < 4000; i++) begin
            i_rst         = ($urandom_range(0, 199) != 0);
            i_ack         = ($urandom_range(0, 2) != 0);
            i_ready       = $urandom_range(0, 1) == 1;
            i_redirect    = ($urandom_range(0, 19) == 0);
            i_redirect_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                        : $urandom;
`ifdef ARVI_FETCH_MISALIGN_EN
            i_redirect_pc = i_redirect_pc & ~32'h3;
`endif
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
